// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Access sizes, FSM state encodings, and the byte-count, spanning and load-extension helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WAIT  = 3'd1;
  localparam state_t ST_BEAT0 = 3'd2;
  localparam state_t ST_BEAT1 = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  // Number of bytes touched by an access; the illegal size touches none.
  function automatic logic [2:0] size_bytes(size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // True when the access runs past the end of its first word.
  function automatic logic is_spanning(logic [1:0] off, size_e sz);
    return ({1'b0, off} + size_bytes(sz)) > 3'd4;
  endfunction

  // Sign- or zero-extend right-justified load data to 32 bits.
  function automatic logic [31:0] extend(logic [31:0] d, size_e sz, logic uns);
    case (sz)
      SZ_BYTE: return uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_HALF: return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      SZ_WORD: return d;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane alignment for the data-memory responder.
// Generates per-word byte enables, shifts store data onto its byte lanes, and pulls
// load data out of a pair of words before extending it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata_ext
);

  logic [7:0]  mask;
  logic [63:0] wide;
  logic [31:0] merged;

  // Lanes span two words: bits [3:0] belong to the low word, [7:4] to the next one.
  always_comb begin
    mask = 8'h00;
    case (size_e'(size))
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      SZ_WORD: mask = 8'h0F;
      default: mask = 8'h00;
    endcase
    mask      = mask << offset;
    wide      = {32'h0, wdata} << {offset, 3'b000};
    merged    = 32'({hi_word, lo_word} >> {offset, 3'b000});
    be_lo     = mask[3:0];
    be_hi     = mask[7:4];
    wdata_lo  = wide[31:0];
    wdata_hi  = wide[63:32];
    rdata_ext = extend(merged, size_e'(size), uns);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the core's load/store port.
// One request at a time over valid/ready, little-endian word array, programmable wait,
// one response per request.
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN -- when defined, accesses crossing a
// word boundary run as two beats; otherwise they are rejected with rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int            IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);
  localparam logic [3:0]    WAIT_LAST   = 4'(LATENCY - 1);
  localparam state_t        FIRST_STATE = (LATENCY > 0) ? ST_WAIT : ST_BEAT0;

  logic [31:0]      mem [DEPTH_WORDS];

  state_t           state;
  logic [3:0]       wait_cnt;
  logic             we_q;
  logic [IDX_W+1:0] addr_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [31:0]      wdata_q;
  logic [31:0]      lo_word_q;

  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [31:0]      lo_rd;
  logic [31:0]      hi_rd;
  logic [31:0]      lo_word_in;
  logic [ADDR_W:0]  req_end;
  logic             req_err;
  logic             span_now;

  logic [3:0]       be_lo;
  logic [3:0]       be_hi;
  logic [31:0]      wdata_lo;
  logic [31:0]      wdata_hi;
  logic [31:0]      rdata_ext;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  assign lo_idx     = addr_q[IDX_W+1:2];
  assign hi_idx     = lo_idx + IDX_W'(1);
  assign lo_rd      = mem[lo_idx];
  assign hi_rd      = mem[hi_idx];
  // The second beat merges against the low word captured during the first beat.
  assign lo_word_in = (state == ST_BEAT1) ? lo_word_q : lo_rd;

  // Request checks: illegal size, any byte past the array, and (without split support) spanning.
  always_comb begin
    req_end  = {1'b0, req_addr} + (ADDR_W + 1)'(size_bytes(size_e'(req_size)));
    span_now = is_spanning(req_addr[1:0], size_e'(req_size));
    req_err  = (size_e'(req_size) == SZ_BAD) || (req_end > ADDR_LIMIT);
`ifndef DMEM_MISALIGN_SPLIT_EN
    req_err  = req_err || span_now;
`endif
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic span_q;
  assign span_q = is_spanning(addr_q[1:0], size_e'(size_q));
`endif

  dmem_lane_align u_align (
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .lo_word   (lo_word_in),
    .hi_word   (hi_rd),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .rdata_ext (rdata_ext)
  );

  // Request/response sequencing: capture at accept, wait, run the beats, hold the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 32'h0;
      lo_word_q <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr[IDX_W+1:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            wait_cnt  <= 4'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= req_err;
            state     <= req_err ? ST_RESP : FIRST_STATE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 4'd0;
            state    <= ST_BEAT0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_BEAT0: begin
          lo_word_q <= lo_rd;
          rsp_rdata <= we_q ? 32'h0 : rdata_ext;
          state     <= ST_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (span_q) state <= ST_BEAT1;
`endif
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        ST_BEAT1: begin
          rsp_rdata <= we_q ? 32'h0 : rdata_ext;
          state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array writes: low-word bytes in the first beat, high-word bytes in the second.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_q && (state == ST_BEAT0) && be_lo[b]) mem[lo_idx][8*b +: 8] <= wdata_lo[8*b +: 8];
      if (we_q && (state == ST_BEAT1) && be_hi[b]) mem[hi_idx][8*b +: 8] <= wdata_hi[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a byte-array model of the memory.
module tb_dmem_responder;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;
  localparam int NBYTES  = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_cyc;
    logic        we;
    int          addr;
    int          nb;
    logic [31:0] wdata;
  } exp_t;

  logic [7:0] mem_model [NBYTES];
  exp_t       cur;
  bit         outstanding;
  bit         seen;
  bit         timed_out;
  logic       prev_req_ready;
  logic       prev_rsp_valid;
  int         cyc;
  int         acc_count;
  int         hs_count;
  int         last_lat;
  int         check_count;
  int         error_count;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected outcome of a request, derived from the byte-array model.
  function automatic exp_t predict(logic we, logic [31:0] addr, logic [1:0] size, logic uns,
                                   logic [31:0] wdata);
    exp_t e;
    int   a;
    bit   span;
    a  = int'(addr);
    e.nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    span = ((a % 4) + e.nb) > 4;
    e.err = (size == 2'd3) || (a + e.nb > NBYTES);
`ifndef DMEM_MISALIGN_SPLIT_EN
    e.err = e.err || span;
`endif
    e.lat   = LATENCY + 1 + ((span && !e.err) ? 1 : 0);
    e.we    = we;
    e.addr  = a;
    e.wdata = wdata;
    e.acc_cyc = 0;
    e.rdata = 32'h0;
    if (!e.err && !we) begin
      for (int i = 0; i < e.nb; i++) e.rdata[8*i +: 8] = mem_model[a + i];
      if (!uns && mem_model[a + e.nb - 1][7]) begin
        for (int i = e.nb; i < 4; i++) e.rdata[8*i +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction

  // Per-cycle monitor: tracks handshakes, updates the model, compares every output.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      outstanding = 0;
      seen        = 0;
      check_output("reset_req_ready", {31'h0, req_ready}, 32'h1);
      check_output("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
      check_output("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
    end else begin
      if (outstanding && prev_rsp_valid && rsp_ready) begin
        hs_count++;
        if (cur.we && !cur.err) begin
          for (int i = 0; i < cur.nb; i++) mem_model[cur.addr + i] = cur.wdata[8*i +: 8];
        end
        outstanding = 0;
      end
      if (prev_req_ready && req_valid) begin
        acc_count++;
        cur         = predict(req_we, req_addr, req_size, req_unsigned, req_wdata);
        cur.acc_cyc = cyc;
        outstanding = 1;
        seen        = 0;
        timed_out   = 0;
      end
      check_output("req_ready", {31'h0, req_ready}, {31'h0, !outstanding});
      if (outstanding) begin
        if (rsp_valid) begin
          if (!seen) begin
            seen     = 1;
            last_lat = cyc - cur.acc_cyc;
            if (!cur.err) check_output("latency", last_lat, cur.lat);
          end
          check_output("rsp_rdata", rsp_rdata, cur.rdata);
          check_output("rsp_err", {31'h0, rsp_err}, {31'h0, cur.err});
        end else if (seen) begin
          check_output("rsp_valid_dropped", {31'h0, rsp_valid}, 32'h1);
        end else if (!timed_out && (cyc - cur.acc_cyc > 40)) begin
          timed_out = 1;
          check_output("rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        end
      end else begin
        check_output("rsp_valid_idle", {31'h0, rsp_valid}, 32'h0);
      end
    end
    prev_req_ready = req_ready;
    prev_rsp_valid = rsp_valid;
  end

  // Issue one request, wait for its response, hold it for 'hold' cycles, then take it.
  task automatic apply_stimulus(input logic we, input int addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input int hold,
                                output logic [31:0] rdata, output logic err);
    int n;
    int guard;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    @(negedge clk);
    req_we       = we;
    req_addr     = addr[31:0];
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    n     = acc_count;
    guard = 0;
    while (acc_count == n && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    if (acc_count == n) begin
      check_output("accept_timeout", 32'h0, 32'h1);
      return;
    end
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) begin
      check_output("response_timeout", 32'h0, 32'h1);
      return;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    n     = hs_count;
    guard = 0;
    while (hs_count == n && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b0;
    if (hs_count == n) check_output("handshake_timeout", 32'h0, 32'h1);
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    int          guard;
    int          r;
    logic [1:0]  sz;

    check_count    = 0;
    error_count    = 0;
    cyc            = 0;
    acc_count      = 0;
    hs_count       = 0;
    last_lat       = 0;
    outstanding    = 0;
    seen           = 0;
    timed_out      = 0;
    prev_req_ready = 1'b0;
    prev_rsp_valid = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = 32'h0;
    req_size       = 2'b00;
    req_unsigned   = 1'b0;
    req_wdata      = 32'h0;
    rsp_ready      = 1'b0;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Give every word a known value so all later loads are predictable.
    for (int w = 0; w < DEPTH; w++) apply_stimulus(1'b1, 4 * w, 2'd2, 1'b0, $urandom, 0, rd, er);

    // Scenario 1: word store and load, with latency.
    apply_stimulus(1'b1, 0, 2'd2, 1'b0, 32'h4865_6C6C, 0, rd, er);
    apply_stimulus(1'b0, 0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t1_lw_data", rd, 32'h4865_6C6C);
    check_output("t1_lw_err", {31'h0, er}, 32'h0);
    check_output("t1_latency", last_lat, 32'd3);

    // Scenario 2: sub-word loads and a byte store with sign extension.
    apply_stimulus(1'b1, 8, 2'd2, 1'b0, 32'h726C_6421, 0, rd, er);
    apply_stimulus(1'b0, 10, 2'd1, 1'b1, 32'h0, 0, rd, er);
    check_output("t2_lhu", rd, 32'h0000_726C);
    apply_stimulus(1'b0, 8, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check_output("t2_lb", rd, 32'h0000_0021);
    apply_stimulus(1'b1, 8, 2'd0, 1'b0, 32'h0000_0080, 0, rd, er);
    apply_stimulus(1'b0, 8, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check_output("t2_lb_neg", rd, 32'hFFFF_FF80);

    // Scenario 3: word load spanning two words.
    apply_stimulus(1'b1, 4, 2'd2, 1'b0, 32'h6F20_776F, 0, rd, er);
    apply_stimulus(1'b1, 8, 2'd2, 1'b0, 32'h726C_6421, 0, rd, er);
    apply_stimulus(1'b0, 6, 2'd2, 1'b0, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_SPLIT_EN
    check_output("t3_span_data", rd, 32'h6421_6F20);
    check_output("t3_span_err", {31'h0, er}, 32'h0);
    check_output("t3_span_latency", last_lat, 32'd4);
`else
    check_output("t3_span_data", rd, 32'h0);
    check_output("t3_span_err", {31'h0, er}, 32'h1);
`endif
    apply_stimulus(1'b0, 4, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t3_word4", rd, 32'h6F20_776F);
    apply_stimulus(1'b0, 8, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t3_word8", rd, 32'h726C_6421);

    // Scenario 4: illegal size and out-of-range accesses.
    apply_stimulus(1'b1, 0, 2'd3, 1'b0, 32'hFFFF_FFFF, 0, rd, er);
    check_output("t4_bad_size_err", {31'h0, er}, 32'h1);
    check_output("t4_bad_size_data", rd, 32'h0);
    apply_stimulus(1'b0, NBYTES, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t4_range_err", {31'h0, er}, 32'h1);
    check_output("t4_range_data", rd, 32'h0);
    apply_stimulus(1'b1, NBYTES - 1, 2'd1, 1'b0, 32'h0000_5555, 0, rd, er);
    check_output("t4_edge_half_err", {31'h0, er}, 32'h1);
    apply_stimulus(1'b0, NBYTES - 1, 2'd0, 1'b1, 32'h0, 0, rd, er);
    check_output("t4_last_byte_err", {31'h0, er}, 32'h0);
    apply_stimulus(1'b0, 0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t4_word0_kept", rd, 32'h4865_6C6C);

    // Scenario 5: response held for five cycles.
    apply_stimulus(1'b0, 4, 2'd2, 1'b0, 32'h0, 5, rd, er);
    check_output("t5_held_data", rd, 32'h6F20_776F);

    // Scenario 6: reset during the wait of a store.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0; req_size = 2'd2; req_unsigned = 1'b0;
    req_wdata = 32'h1122_3344; req_valid = 1'b1;
    n = acc_count;
    guard = 0;
    while (acc_count == n && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    if (acc_count == n) check_output("t6_accept_timeout", 32'h0, 32'h1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_output("t6_req_ready", {31'h0, req_ready}, 32'h1);
    apply_stimulus(1'b0, 0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check_output("t6_word0_kept", rd, 32'h4865_6C6C);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, NBYTES + 3), sz,
                     1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), rd, er);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
